// File: rtl/xlate_rr_sched.sv
// Round-robin arbiter sharing one 2-bit translation unit (out = 3 - in) among NREQ requesters.
// One request in flight at a time; the result is sampled LAT cycles after xl_inp is driven and is held until rsp_ready.
module xlate_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_code,
  output logic [NREQ-1:0]   req_ready,
  output logic [1:0]        xl_inp,
  input  logic [1:0]        xl_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [1:0]        rsp_data,
  output logic              busy,
  output logic [7:0]        mismatch_cnt
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, XLATE, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, id_q, win;
  logic           any_vld;
  logic [CW-1:0]  cnt;

  function automatic int wrap(input int a);
    return (a >= NREQ) ? a - NREQ : a;
  endfunction

  // Scan downward so the candidate closest to ptr is the last one written.
  always_comb begin
    win     = '0;
    any_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[wrap(int'(ptr) + k)]) begin
        win     = IDW'(wrap(int'(ptr) + k));
        any_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (any_vld) begin
          req_ready[win] = rst;
          state_nxt      = XLATE;
        end
      end
      XLATE:   if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      id_q         <= '0;
      cnt          <= '0;
      xl_inp       <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      mismatch_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_vld) begin
            xl_inp <= req_code[2*win +: 2];
            id_q   <= win;
            cnt    <= CW'(LAT - 1);
            ptr    <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
          end
        end
        XLATE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_data  <= xl_out;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            // Only the sampled result is judged; the unit may still be settling earlier.
            if (xl_out != 2'd3 - xl_inp && mismatch_cnt != 8'hFF)
              mismatch_cnt <= mismatch_cnt + 1'b1;
          end
        end
        RESP:    if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xlate_rr_sched.sv
// Bench for xlate_rr_sched: vector table, directed corner sequences and a randomized run against a transaction model.
// Two instances share stimulus: one with LAT=1, one with LAT=3.
module tb_xlate_rr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [7:0] req_code;
  logic       rsp_ready;
  logic       force_zero;

  logic [3:0] rdy1, rdy3;
  logic [1:0] xi1, xi3, xo1, xo3, rid1, rid3, rd1, rd3;
  logic       rv1, rv3, busy1, busy3;
  logic [7:0] mc1, mc3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural translation unit, with an optional fault that maps code 0 to 0.
  assign xo1 = (force_zero && xi1 == 2'd0) ? 2'd0 : 2'd3 - xi1;
  assign xo3 = (force_zero && xi3 == 2'd0) ? 2'd0 : 2'd3 - xi3;

  xlate_rr_sched #(.NREQ(4), .IDW(2), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_code(req_code), .req_ready(rdy1),
    .xl_inp(xi1), .xl_out(xo1), .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_id(rid1),
    .rsp_data(rd1), .busy(busy1), .mismatch_cnt(mc1)
  );

  xlate_rr_sched #(.NREQ(4), .IDW(2), .LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_code(req_code), .req_ready(rdy3),
    .xl_inp(xi3), .xl_out(xo3), .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_id(rid3),
    .rsp_data(rd3), .busy(busy3), .mismatch_cnt(mc3)
  );

  typedef struct {
    logic [3:0] vld;
    logic [7:0] code;
    int         id;
    int         data;
  } vec_t;

  vec_t tbl[7];
  int   got_id[$];
  int   got_data[$];
  int   got_cyc[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    req_code  = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic collect(input int want, input int budget);
    got_id.delete();
    got_data.delete();
    got_cyc.delete();
    for (int c = 0; c < budget && got_id.size() < want; c++) begin
      @(negedge clk);
      #1;
      if (rv1) begin
        got_id.push_back(int'(rid1));
        got_data.push_back(int'(rd1));
        got_cyc.push_back(c);
      end
    end
  endtask

  initial begin
    int exp_a_id[4];
    int exp_a_dat[4];
    int exp_b_id[4];
    bit seen;
    int n;
    int mptr, rsp_at, exp_id, exp_data, w, exp_rdy;
    bit pend;

    force_zero = 1'b0;
    tbl[0] = '{4'b0001, 8'hE4, 0, 3};
    tbl[1] = '{4'b1111, 8'h1B, 1, 1};
    tbl[2] = '{4'b0011, 8'h1B, 0, 0};
    tbl[3] = '{4'b1000, 8'hE4, 3, 0};
    tbl[4] = '{4'b1110, 8'h1B, 1, 1};
    tbl[5] = '{4'b0100, 8'hE4, 2, 1};
    tbl[6] = '{4'b0111, 8'hE4, 0, 3};
    exp_a_id  = '{0, 1, 2, 3};
    exp_a_dat = '{3, 2, 1, 0};
    exp_b_id  = '{1, 3, 1, 3};

    // Reset state, with requests pending to prove req_ready is masked.
    rst = 1'b0; req_valid = 4'hF; req_code = 8'hE4; rsp_ready = 1'b1;
    #1;
    chk("rst_ready", int'(rdy1), 0);
    chk("rst_rsp_valid", int'(rv1), 0);
    chk("rst_rsp_id", int'(rid1), 0);
    chk("rst_rsp_data", int'(rd1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_mcnt", int'(mc1), 0);
    chk("rst_xl_inp", int'(xi1), 0);
    chk("rst_mcnt3", int'(mc3), 0);

    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_valid = tbl[i].vld; req_code = tbl[i].code; rsp_ready = 1'b1;
      #1;
      chk("tbl_grant", int'(rdy1), 1 << tbl[i].id);
      chk("tbl_idle_busy", int'(busy1), 0);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("tbl_xlate_busy", int'(busy1), 1);
      chk("tbl_xlate_rv", int'(rv1), 0);
      chk("tbl_xlate_ready", int'(rdy1), 0);
      @(negedge clk);
      #1;
      chk("tbl_rv", int'(rv1), 1);
      chk("tbl_id", int'(rid1), tbl[i].id);
      chk("tbl_data", int'(rd1), tbl[i].data);
      chk("tbl_resp_busy", int'(busy1), 1);
      @(negedge clk);
      #1;
      chk("tbl_done_busy", int'(busy1), 0);
      chk("tbl_done_rv", int'(rv1), 0);
    end

    // All four requesters held: strict rotation, 3-cycle spacing.
    do_reset();
    req_valid = 4'hF; req_code = 8'hE4;
    collect(4, 40);
    chk("all_count", got_id.size(), 4);
    for (int i = 0; i < got_id.size(); i++) begin
      chk("all_id", got_id[i], exp_a_id[i]);
      chk("all_data", got_data[i], exp_a_dat[i]);
      if (i > 0) chk("all_spacing", got_cyc[i] - got_cyc[i-1], 3);
    end
    chk("all_mcnt", int'(mc1), 0);

    // Fairness between requesters 1 and 3.
    do_reset();
    req_valid = 4'b1010; req_code = 8'hE4;
    collect(4, 40);
    chk("fair_count", got_id.size(), 4);
    for (int i = 0; i < got_id.size(); i++) chk("fair_id", got_id[i], exp_b_id[i]);

    // Backpressure: response held, no grants while stalled.
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001; req_code = 8'h01; rsp_ready = 1'b0;
    #1;
    chk("bp_grant", int'(rdy1), 1);
    @(negedge clk);
    req_valid = 4'hF;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (rv1) seen = 1'b1;
    end
    chk("bp_seen", int'(seen), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("bp_rv", int'(rv1), 1);
      chk("bp_id", int'(rid1), 0);
      chk("bp_data", int'(rd1), 2);
      chk("bp_ready", int'(rdy1), 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp_last_rv", int'(rv1), 1);
    chk("bp_last_ready", int'(rdy1), 0);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("bp_after_rv", int'(rv1), 0);
    chk("bp_next_grant", int'(rdy1), 4'b0010);

    // Reset in the middle of a translation with ptr=2.
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010; req_code = 8'h08; rsp_ready = 1'b1;
    #1;
    chk("rx_grant", int'(rdy1), 4'b0010);
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    chk("rx_busy", int'(busy1), 1);
    chk("rx_xl_inp", int'(xi1), 2);
    rst = 1'b0;
    #1;
    chk("rx_xl_inp0", int'(xi1), 0);
    chk("rx_busy0", int'(busy1), 0);
    chk("rx_rv0", int'(rv1), 0);
    chk("rx_ready0", int'(rdy1), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rx_first_grant", int'(rdy1), 4'b0001);

    // Randomized run against a transaction-level model (LAT=1).
    do_reset();
    mptr = 0; pend = 1'b0; rsp_at = 0; exp_id = 0; exp_data = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      req_valid = 4'($urandom);
      req_code  = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      w = -1;
      if (!pend) begin
        for (int k = 3; k >= 0; k--)
          if (req_valid[(mptr + k) % 4]) w = (mptr + k) % 4;
      end
      exp_rdy = (w >= 0) ? (1 << w) : 0;
      chk("rnd_ready", int'(rdy1), exp_rdy);
      chk("rnd_busy", int'(busy1), int'(pend));
      if (pend && cyc >= rsp_at) begin
        chk("rnd_rv", int'(rv1), 1);
        chk("rnd_id", int'(rid1), exp_id);
        chk("rnd_data", int'(rd1), exp_data);
      end else begin
        chk("rnd_rv", int'(rv1), 0);
      end
      if (w >= 0) begin
        pend     = 1'b1;
        rsp_at   = cyc + 2;
        exp_id   = w;
        exp_data = 3 - int'((req_code >> (2 * w)) & 8'h3);
        mptr     = (w + 1) % 4;
      end else if (pend && cyc >= rsp_at && rsp_ready) begin
        pend = 1'b0;
      end
    end
    chk("rnd_mcnt", int'(mc1), 0);

    // LAT=3 with a faulty unit: latency, uncorrected data, saturating count.
    do_reset();
    force_zero = 1'b1;
    @(negedge clk);
    req_valid = 4'b0001; req_code = 8'h00; rsp_ready = 1'b1;
    #1;
    chk("l3_grant", int'(rdy3), 1);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      #1;
      chk("l3_rv_early", int'(rv3), 0);
    end
    @(negedge clk);
    #1;
    chk("l3_rv", int'(rv3), 1);
    chk("l3_id", int'(rid3), 0);
    chk("l3_data", int'(rd3), 0);
    chk("l3_mcnt1", int'(mc3), 1);
    n = 1;
    for (int c = 0; c < 4000 && n < 300; c++) begin
      @(negedge clk);
      #1;
      if (rv3) n++;
    end
    chk("l3_rsp_count", n, 300);
    chk("l3_mcnt_sat", int'(mc3), 255);
    chk("l1_mcnt_sat", int'(mc1), 255);
    force_zero = 1'b0;
    req_valid  = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xlate_rr_sched.md
Name: xlate_rr_sched

Overview:
Round-robin scheduler that shares one 2-bit code-translation unit (combinational full/parallel-case map, out = 3 - in) among NREQ requesters. It accepts one request at a time with a valid/ready handshake and drives the shared unit's input. After a configurable settle latency it samples the result and returns it, tagged with the requester ID, on a single response channel with backpressure. It also counts results that do not match the expected inverse mapping.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width, equal to clog2(NREQ)
LAT, 1, cycles between driving xl_inp and sampling xl_out (1..4)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  NREQ  per-requester request valid
req_code  input  2*NREQ  per-requester 2-bit code; requester i uses bits [2i+1:2i]
req_ready  output  NREQ  one-hot grant/accept; combinational
xl_inp  output  2  registered input to the shared translation unit
xl_out  input  2  result from the shared translation unit
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  IDW  ID of the requester being answered
rsp_data  output  2  sampled xl_out
busy  output  1  high when state != IDLE
mismatch_cnt  output  8  saturating count of xl_out != 3 - code

Behaviour:
- Reset (rst low, asynchronous) clears the following:
  - state to IDLE, rr pointer to 0, wait counter to 0.
  - xl_inp, rsp_valid, rsp_id, rsp_data, busy and mismatch_cnt all to 0.
  - req_ready is all-zero while rst is low.
- FSM has three states: IDLE, XLATE, RESP.
- IDLE:
  - If any req_valid is set, the winner w is the first set bit searching upward from ptr, wrapping modulo NREQ.
  - req_ready[w]=1 combinationally in that cycle; all other req_ready bits are 0. A handshake occurs on that clock edge.
  - On the edge: latch code_w into xl_inp and w into id_q; set cnt=LAT-1; set ptr=(w+1) mod NREQ; go to XLATE.
  - If no req_valid is set, stay in IDLE with req_ready=0.
- XLATE:
  - xl_inp is held stable.
  - If cnt>0: decrement cnt.
  - If cnt==0: capture rsp_data=xl_out and rsp_id=id_q; set rsp_valid=1; go to RESP.
  - Compare xl_out against (3 - xl_inp). On a mismatch, increment mismatch_cnt, saturating at 255.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready is high on an edge.
  - On that edge: rsp_valid=0, go to IDLE.
  - No new grant is made in RESP or XLATE; req_ready=0 in both states.
- Latency: with acceptance edge at cycle T, rsp_valid is first high in cycle T+LAT+1.
  - Minimum request-to-request spacing is LAT+2 cycles when rsp_ready is held high.
- A requester dropping req_valid while not granted has no effect. Requests are never lost once granted.
- xl_inp retains its last value in IDLE; it is not cleared.
- rsp_data passes the actual xl_out value even on a mismatch; it is not corrected.
- Reset asserted mid-XLATE or mid-RESP aborts the operation. No response is issued for the in-flight request, and ptr returns to 0.

Test Plan:
- Single request, LAT=1: req_valid=4'b0001, code0=0 -> req_ready=0001 for 1 cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_data=3; busy high for 2 cycles.
- All four requesters valid with codes 0,1,2,3 held, rsp_ready=1 -> responses in order id 0,1,2,3 with data 3,2,1,0; spacing 3 cycles (LAT=1); mismatch_cnt=0.
- Fairness: req_valid=4'b1010 held continuously -> grants alternate 1,3,1,3; requesters 0 and 2 are never granted.
- Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_valid/rsp_id/rsp_data stable and req_ready=0 throughout; on the rsp_ready edge, return to IDLE and grant the next requester the following cycle.
- LAT=3 with xl_out forced to 0 for code 0 -> rsp_data=0 at T+4; mismatch_cnt=1; 300 such requests leave mismatch_cnt saturated at 255.
- Reset during XLATE with ptr=2 -> all outputs 0 asynchronously; after release, req_valid=4'b1111 grants requester 0 first.
